// File: rtl/bram_wr_ctrl.sv
// AXI4-Stream slave that loads one D2Q9 lattice frame into the nine per-direction BRAM banks.
// Each beat holds the nine distributions of one cell; beats land at consecutive addresses 0..DEPTH-1.
module bram_wr_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_areset,
    input  logic                      load_start,
    input  logic                      bank_hold,
    input  logic                      s00_axis_tvalid,
    output logic                      s00_axis_tready,
    input  logic [9*DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [9*DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                      s00_axis_tlast,
    output logic                      write_en,
    output logic [ADDRESS_WIDTH-1:0]  write_addr,
    output logic [DATA_WIDTH-1:0]     n0,
    output logic [DATA_WIDTH-1:0]     null0,
    output logic [DATA_WIDTH-1:0]     ne0,
    output logic [DATA_WIDTH-1:0]     e0,
    output logic [DATA_WIDTH-1:0]     se0,
    output logic [DATA_WIDTH-1:0]     s0,
    output logic [DATA_WIDTH-1:0]     sw0,
    output logic [DATA_WIDTH-1:0]     w0,
    output logic [DATA_WIDTH-1:0]     nw0,
    output logic                      frame_loaded,
    output logic                      busy,
    output logic                      tlast_err
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                   state, next_state;
    logic [ADDRESS_WIDTH-1:0] count;
    logic                     handshake;
    logic                     last_beat;
    logic                     unused_strb;

    // Only full beats are ever sent, so the strobes carry no information.
    assign unused_strb = ^s00_axis_tstrb;

    assign s00_axis_tready = (state == RECV) && !bank_hold;
    assign handshake       = s00_axis_tvalid && s00_axis_tready;
    assign last_beat       = (count == LAST_ADDR);
    assign busy            = (state == RECV);
    assign frame_loaded    = (state == DONE);

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) state <= IDLE;
        else                 state <= next_state;
    end

    // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_start) next_state = RECV;
            RECV:    if (handshake && (last_beat || s00_axis_tlast)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            count      <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            n0         <= '0;
            null0      <= '0;
            ne0        <= '0;
            e0         <= '0;
            se0        <= '0;
            s0         <= '0;
            sw0        <= '0;
            w0         <= '0;
            nw0        <= '0;
            tlast_err  <= 1'b0;
        end else begin
            if (state == IDLE && load_start) begin
                count     <= '0;
                tlast_err <= 1'b0;
            end
            write_en <= handshake;
            if (handshake) begin
                write_addr <= count;
                n0         <= s00_axis_tdata[8*DATA_WIDTH +: DATA_WIDTH];
                null0      <= s00_axis_tdata[7*DATA_WIDTH +: DATA_WIDTH];
                ne0        <= s00_axis_tdata[6*DATA_WIDTH +: DATA_WIDTH];
                e0         <= s00_axis_tdata[5*DATA_WIDTH +: DATA_WIDTH];
                se0        <= s00_axis_tdata[4*DATA_WIDTH +: DATA_WIDTH];
                s0         <= s00_axis_tdata[3*DATA_WIDTH +: DATA_WIDTH];
                sw0        <= s00_axis_tdata[2*DATA_WIDTH +: DATA_WIDTH];
                w0         <= s00_axis_tdata[1*DATA_WIDTH +: DATA_WIDTH];
                nw0        <= s00_axis_tdata[0*DATA_WIDTH +: DATA_WIDTH];
                // Saturate on the final cell so count never names an address past the frame.
                if (!last_beat) count <= count + 1'b1;
                // tlast must coincide exactly with the final cell; early or missing both flag.
                if (s00_axis_tlast != last_beat) tlast_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_wr_ctrl.sv
// Scoreboard bench for bram_wr_ctrl: the driver queues the expected bank write for every accepted beat,
// an independent monitor pops and compares each write_en cycle.
module tb_bram_wr_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 2500;
    localparam int AW    = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start, bank_hold, tvalid, tlast;
    logic            tready;
    logic [9*DW-1:0] tdata;
    logic [17:0]     tstrb;
    logic            write_en;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   n0, null0, ne0, e0, se0, s0, sw0, w0, nw0;
    logic            frame_loaded, busy, tlast_err;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [9*DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;
    int  pulses = 0;

    always #5 clk = ~clk;

    bram_wr_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .load_start      (load_start),
        .bank_hold       (bank_hold),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tlast  (tlast),
        .write_en        (write_en),
        .write_addr      (write_addr),
        .n0              (n0),
        .null0           (null0),
        .ne0             (ne0),
        .e0              (e0),
        .se0             (se0),
        .s0              (s0),
        .sw0             (sw0),
        .w0              (w0),
        .nw0             (nw0),
        .frame_loaded    (frame_loaded),
        .busy            (busy),
        .tlast_err       (tlast_err)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane i of cell a carries a*9+i; lane 0 is the low slice (nw), lane 8 the high slice (n).
    function automatic logic [9*DW-1:0] beat(input int a);
        logic [9*DW-1:0] r;
        for (int i = 0; i < 9; i++) r[16*i +: 16] = 16'(a * 9 + i);
        return r;
    endfunction

    // Monitor: every bank write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_loaded) pulses++;
            if (write_en) begin
                writes++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d expected no write", write_addr);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 160'(write_addr), 160'(e.addr));
                    check("wr_lanes", 160'({n0, null0, ne0, e0, se0, s0, sw0, w0, nw0}), 160'(e.data));
                    check("wr_e0", 160'(e0), 160'(16'(int'(e.addr) * 9 + 5)));
                    check("wr_n0", 160'(n0), 160'(16'(int'(e.addr) * 9 + 8)));
                end
            end
        end
    end

    task automatic run_frame(input string tag, input int n_beats, input int last_idx,
                             input bit hold_toggle, input bit rand_valid,
                             input bit exp_err, input bit post_valid);
        int idx = 0;
        int cyc = 0;
        int w_start = writes;
        int p_start = pulses;
        // load_start together with a valid beat: nothing may be taken in that cycle
        @(posedge clk); #1;
        load_start = 1'b1; tvalid = 1'b1; tdata = beat(0); tlast = 1'b0; bank_hold = 1'b0;
        @(negedge clk);
        check({tag, "_tready_on_start"}, 160'(tready), 160'(0));
        @(posedge clk); #1;
        load_start = 1'b0;
        while (idx < n_beats && cyc < n_beats * 8 + 100) begin
            bank_hold = hold_toggle ? ((cyc / 3) % 2 == 1) : 1'b0;
            tvalid    = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            tdata     = beat(idx);
            tlast     = (idx == last_idx);
            @(negedge clk);
            if (cyc == 0) check({tag, "_busy_recv"}, 160'(busy), 160'(1));
            if (bank_hold) check({tag, "_tready_hold"}, 160'(tready), 160'(0));
            if (tvalid && tready) begin
                sb.push_back('{addr: AW'(idx), data: beat(idx)});
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_beats_accepted"}, 160'(idx), 160'(n_beats));
        bank_hold = 1'b0;
        tvalid    = post_valid;
        tdata     = beat(idx);
        tlast     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check({tag, "_tready_after"}, 160'(tready), 160'(0));
            @(posedge clk); #1;
        end
        check({tag, "_write_count"}, 160'(writes - w_start), 160'(n_beats));
        check({tag, "_frame_pulses"}, 160'(pulses - p_start), 160'(1));
        check({tag, "_tlast_err"}, 160'(tlast_err), 160'(exp_err));
        check({tag, "_busy_after"}, 160'(busy), 160'(0));
        check({tag, "_sb_empty"}, 160'(sb.size()), 160'(0));
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; bank_hold = 1'b0; tvalid = 1'b0;
        tlast = 1'b0; tdata = '0; tstrb = '1;
        #1;
        check("rst_ctrl", 160'({tready, write_en, write_addr, frame_loaded, busy, tlast_err}), 160'(0));
        check("rst_lanes", 160'({n0, null0, ne0, e0, se0, s0, sw0, w0, nw0}), 160'(0));
        #22 rst = 1'b0;

        // T6: valid without load_start stays upstream
        @(posedge clk); #1;
        tvalid = 1'b1; tdata = beat(7);
        repeat (50) begin
            @(negedge clk);
            check("idle_tready", 160'(tready), 160'(0));
            check("idle_write_en", 160'(write_en), 160'(0));
            check("idle_busy", 160'(busy), 160'(0));
        end
        tvalid = 1'b0;

        run_frame("full", DEPTH, DEPTH - 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("bp", DEPTH, DEPTH - 1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame("early", 100, 99, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame("missing", DEPTH, -1, 1'b0, 1'b0, 1'b1, 1'b1);

        // load_start clears the sticky error and re-arms
        @(posedge clk); #1;
        tvalid = 1'b0; load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        @(negedge clk);
        check("rearm_tlast_err", 160'(tlast_err), 160'(0));
        check("rearm_busy", 160'(busy), 160'(1));

        // T1: reset mid-frame aborts; outputs clear immediately
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            tvalid = 1'b1; tdata = beat(i); tlast = 1'b0;
            @(negedge clk);
            if (tready) sb.push_back('{addr: AW'(i), data: beat(i)});
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 160'({tready, write_en, write_addr, frame_loaded, busy, tlast_err}), 160'(0));
        check("mid_rst_lanes", 160'({n0, null0, ne0, e0, se0, s0, sw0, w0, nw0}), 160'(0));
        sb.delete();
        #23 rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_write_en", 160'(write_en), 160'(0));
            check("post_rst_tready", 160'(tready), 160'(0));
        end
        tvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
